// File: rtl/chart_sequencer.sv
// -----------------------------------------------------------------------------
// chart_sequencer
//
// Chart playback engine for the rhythm game. A step chart of {arrows, timing}
// entries is loaded into an internal synchronous 1R1W RAM while the engine is
// idle. After start_i, every beat tick (next_i) presents the next step to the
// judge/display logic. Each fetch is two cycles long. A next_i that arrives
// during a fetch is dropped and latched in a sticky overrun flag.
//
// Optional feature macro: CHART_SEQUENCER_LOOP_EN
//   When defined, the loop_i input is added. A next_i on the last step with
//   loop_i high wraps playback back to entry 0 instead of finishing.
//
// Parameters:
//   LANES_P     number of arrow lanes (width of arrows_o)
//   TIMING_W_P  width of the per-step timing field
//   DEPTH_P     chart entries (power of two, >= 2)
//   ADDR_W_P    derived address width, do not override
//
// Ports:
//   clk_i         clock, rising edge
//   reset_ni      asynchronous active-low reset
//   start_i       begin playback from entry 0 (pulse)
//   stop_i        abort playback, return to idle
//   next_i        beat tick, advance one step
//   length_i      chart length in entries, sampled on an accepted start
//   wr_valid_i    chart load strobe (ignored while busy)
//   wr_addr_i     chart load address
//   wr_data_i     chart load data {arrows, timing}
//   loop_i        (optional) wrap to entry 0 at end of chart
//   arrows_o      current step arrows
//   timing_o      current step timing
//   step_valid_o  one-cycle pulse when a new step is presented
//   busy_o        fetching or playing
//   done_o        chart finished
//   overrun_o     sticky, a beat tick was dropped
// -----------------------------------------------------------------------------
module chart_sequencer #(
  parameter int LANES_P    = 4,
  parameter int TIMING_W_P = 4,
  parameter int DEPTH_P    = 128,
  parameter int ADDR_W_P   = $clog2(DEPTH_P)
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic                          next_i,
  input  logic [ADDR_W_P:0]             length_i,
  input  logic                          wr_valid_i,
  input  logic [ADDR_W_P-1:0]           wr_addr_i,
  input  logic [LANES_P+TIMING_W_P-1:0] wr_data_i,
`ifdef CHART_SEQUENCER_LOOP_EN
  input  logic                          loop_i,
`endif
  output logic [LANES_P-1:0]            arrows_o,
  output logic [TIMING_W_P-1:0]         timing_o,
  output logic                          step_valid_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          overrun_o
);

  localparam int DATA_W_L = LANES_P + TIMING_W_P;
  localparam logic [ADDR_W_P:0] DEPTH_C = (ADDR_W_P+1)'(DEPTH_P);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  logic [DATA_W_L-1:0]   mem_q [DEPTH_P];
  state_e                state_q;
  logic                  fetch_ph_q;
  logic [ADDR_W_P-1:0]   addr_q;
  logic [ADDR_W_P:0]     len_q;
  logic [LANES_P-1:0]    arrows_q;
  logic [TIMING_W_P-1:0] timing_q;
  logic                  step_valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  overrun_q;

  logic [ADDR_W_P:0]     length_sat;
  logic [ADDR_W_P:0]     last_addr;
  logic                  last_step;
  logic                  wr_en;
  logic                  wrap_en;
  logic [DATA_W_L-1:0]   rd_data;

`ifdef CHART_SEQUENCER_LOOP_EN
  assign wrap_en = loop_i;
`else
  assign wrap_en = 1'b0;
`endif

  // Writes are locked out while playback owns the RAM, so a read and a write
  // can never hit the same entry in one cycle.
  assign wr_en   = wr_valid_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign rd_data = mem_q[addr_q];

  // Saturate the requested length to the chart depth.
  always_comb begin
    length_sat = length_i;
    if (length_i > DEPTH_C) begin
      length_sat = DEPTH_C;
    end else begin
      length_sat = length_i;
    end
  end

  // End-of-chart detection; compared one bit wider so length == DEPTH_P works.
  always_comb begin
    last_addr = len_q - (ADDR_W_P+1)'(1);
    last_step = 1'b0;
    if ({1'b0, addr_q} == last_addr) begin
      last_step = 1'b1;
    end else begin
      last_step = 1'b0;
    end
  end

  // Chart RAM write port (contents are deliberately not reset).
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Playback FSM with registered outputs; priority is stop > start > next.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_IDLE;
      fetch_ph_q   <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      arrows_q     <= '0;
      timing_q     <= '0;
      step_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      step_valid_q <= 1'b0;
      if (stop_i) begin
        state_q    <= ST_IDLE;
        fetch_ph_q <= 1'b0;
        arrows_q   <= '0;
        timing_q   <= '0;
        busy_q     <= 1'b0;
        done_q     <= 1'b0;
      end else if (start_i) begin
        // Accepted start clears overrun even if a tick is dropped this cycle.
        addr_q     <= '0;
        len_q      <= length_sat;
        overrun_q  <= 1'b0;
        fetch_ph_q <= 1'b0;
        if (length_sat == '0) begin
          state_q  <= ST_DONE;
          arrows_q <= '0;
          timing_q <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end else begin
          state_q  <= ST_FETCH;
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          ST_DONE: begin
            state_q <= ST_DONE;
          end
          ST_FETCH: begin
            if (next_i) begin
              overrun_q <= 1'b1;
            end
            if (!fetch_ph_q) begin
              // The RAM read register doubles as the output register.
              arrows_q     <= rd_data[DATA_W_L-1:TIMING_W_P];
              timing_q     <= rd_data[TIMING_W_P-1:0];
              step_valid_q <= 1'b1;
              fetch_ph_q   <= 1'b1;
            end else begin
              fetch_ph_q   <= 1'b0;
              state_q      <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (next_i) begin
              if (!last_step) begin
                addr_q     <= addr_q + ADDR_W_P'(1);
                fetch_ph_q <= 1'b0;
                state_q    <= ST_FETCH;
              end else if (wrap_en) begin
                addr_q     <= '0;
                fetch_ph_q <= 1'b0;
                state_q    <= ST_FETCH;
              end else begin
                state_q    <= ST_DONE;
                arrows_q   <= '0;
                timing_q   <= '0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
              end
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            fetch_ph_q <= 1'b0;
            arrows_q   <= '0;
            timing_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign arrows_o     = arrows_q;
  assign timing_o     = timing_q;
  assign step_valid_o = step_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overrun_o    = overrun_q;

endmodule
